// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DIV_LATENCY   = 33;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN
    } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when that leaves a non-negative partial remainder.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // A set top bit means the shifted remainder already exceeds any WIDTH-bit divisor;
    // otherwise bit WIDTH of the difference is the borrow.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, div_i};
        qbit_o  = shifted[WIDTH] | ~diff[WIDTH];
        rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_div.sv
// Fixed-latency signed/unsigned sequential divider: one restoring step per cycle,
// sign fix-up in a final cycle, results held until the next completion.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic               negQ_q, negQ_d;
    logic               negR_q, negR_d;
    logic               divZero_q, divZero_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   remOut_q, remOut_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   stepRem;
    logic               stepQbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (acc_q),
        .div_i  (dsr_q),
        .bit_i  (dvd_q[WIDTH-1]),
        .rem_o  (stepRem),
        .qbit_o (stepQbit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            dvd_q     <= '0;
            acc_q     <= '0;
            dsr_q     <= '0;
            negQ_q    <= 1'b0;
            negR_q    <= 1'b0;
            divZero_q <= 1'b0;
            quot_q    <= '0;
            remOut_q  <= '0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            dvd_q     <= dvd_d;
            acc_q     <= acc_d;
            dsr_q     <= dsr_d;
            negQ_q    <= negQ_d;
            negR_q    <= negR_d;
            divZero_q <= divZero_d;
            quot_q    <= quot_d;
            remOut_q  <= remOut_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
        end
    end

    // The dividend register doubles as the quotient: bits leave at the top while
    // quotient bits enter at the bottom, so after WIDTH steps it holds |q|.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        dvd_d     = dvd_q;
        acc_d     = acc_q;
        dsr_d     = dsr_q;
        negQ_d    = negQ_q;
        negR_d    = negR_q;
        divZero_d = divZero_q;
        quot_d    = quot_q;
        remOut_d  = remOut_q;
        dz_d      = dz_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d     = (sign && a[WIDTH-1]) ? -a : a;
                    dsr_d     = (sign && b[WIDTH-1]) ? -b : b;
                    negQ_d    = sign && (a[WIDTH-1] != b[WIDTH-1]);
                    negR_d    = sign && a[WIDTH-1];
                    divZero_d = (b == '0);
                    acc_d     = '0;
                    count_d   = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                dvd_d   = {dvd_q[WIDTH-2:0], stepQbit};
                acc_d   = stepRem;
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                // With a zero divisor the sign-corrected remainder is already a, but the quotient must be forced.
                if (divZero_q) begin
                    quot_d = '1;
                end else begin
                    quot_d = negQ_q ? -dvd_q : dvd_q;
                end
                remOut_d = negR_q ? -acc_q : acc_q;
                dz_d     = divZero_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign q    = quot_q;
    assign r    = remOut_q;
    assign dz   = dz_q;

endmodule
